// File: rtl/ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter
//
// Controller placed in front of a 32x8 dual-port RAM. It shares the single
// RAM write port between two requesters using a req/ack handshake, runs a
// bulk-clear sequencer that zero-fills every word, and drives the read port
// with a free-running scan address that steps once per tick period.
//
// Optional build macro:
//   ARB_FIXED_PRIO_EN - requester 0 always wins a tie; the round-robin
//                       last-grant state is removed. Undefined (default):
//                       round-robin arbitration.
//
// Ports:
//   clock_i      system clock
//   resetn_i     asynchronous active-low reset
//   req_i        write request per requester (bit i = requester i)
//   addr0_i      requester 0 write address
//   data0_i      requester 0 write data
//   addr1_i      requester 1 write address
//   data1_i      requester 1 write data
//   ack_o        one-cycle grant/done pulse per requester
//   clr_start_i  pulse that starts the bulk clear
//   clr_busy_o   high while the clear is running
//   scan_en_i    enables read-address stepping
//   ram_wren_o   RAM write enable
//   ram_waddr_o  RAM write address
//   ram_din_o    RAM write data
//   ram_raddr_o  RAM read address
// -----------------------------------------------------------------------------
module ram_access_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int TICKS = 50000000,
    parameter int TW    = 26
) (
    input  logic          clock_i,
    input  logic          resetn_i,
    input  logic [1:0]    req_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] data0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] data1_i,
    output logic [1:0]    ack_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o,
    input  logic          scan_en_i,
    output logic          ram_wren_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_din_o,
    output logic [AW-1:0] ram_raddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_ZERO = '0;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [DW-1:0] DATA_ZERO = '0;
    localparam logic [TW-1:0] TICK_ZERO = '0;
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

    state_t        state_q,    state_d;
    logic          clr_pend_q, clr_pend_d;
    logic          wren_q,     wren_d;
    logic [AW-1:0] waddr_q,    waddr_d;
    logic [DW-1:0] din_q,      din_d;
    logic [1:0]    ack_q,      ack_d;
    logic          busy_q,     busy_d;
    logic [TW-1:0] tick_q,     tick_d;
    logic [AW-1:0] raddr_q,    raddr_d;
`ifndef ARB_FIXED_PRIO_EN
    logic          last_grant_q, last_grant_d;
`endif

    // Index of the requester that would win if a grant were issued this cycle.
    logic          win_s;

    // Arbitration: select the winner among the active requests.
    always_comb begin
        win_s = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        if (req_i[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        // On a tie, the requester that was not served last goes first.
        if (req_i == 2'b11) begin
            win_s = ~last_grant_q;
        end else if (req_i[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // Control FSM: next state and next values of the write-side outputs.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        wren_d     = 1'b0;
        waddr_d    = waddr_q;
        din_d      = din_q;
        ack_d      = 2'b00;
        busy_d     = busy_q;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A clear (new or deferred) outranks any write request.
                if (clr_pend_q || clr_start_i) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    busy_d     = 1'b1;
                    wren_d     = 1'b1;
                    waddr_d    = ADDR_ZERO;
                    din_d      = DATA_ZERO;
                end else if (req_i != 2'b00) begin
                    state_d = ST_WRITE;
                    wren_d  = 1'b1;
                    if (win_s) begin
                        waddr_d = addr1_i;
                        din_d   = data1_i;
                        ack_d   = 2'b10;
                    end else begin
                        waddr_d = addr0_i;
                        din_d   = data0_i;
                        ack_d   = 2'b01;
                    end
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_d = win_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Single-cycle write; a clear arriving now is deferred.
                state_d = ST_IDLE;
                if (clr_start_i) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
            end
            ST_CLEAR: begin
                // Clear requests during a clear queue another full pass later.
                if (clr_start_i) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
                // The write address register doubles as the clear address.
                if (waddr_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    wren_d  = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                    wren_d  = 1'b1;
                    waddr_d = waddr_q + ADDR_ONE;
                    din_d   = DATA_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read scan: tick divider and read-address stepping, independent of the FSM.
    always_comb begin
        tick_d  = tick_q;
        raddr_d = raddr_q;
        if (scan_en_i) begin
            if (tick_q == TICK_LAST) begin
                tick_d  = TICK_ZERO;
                raddr_d = raddr_q + ADDR_ONE;
            end else begin
                tick_d  = tick_q + TICK_ONE;
                raddr_d = raddr_q;
            end
        end else begin
            tick_d  = tick_q;
            raddr_d = raddr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= 1'b0;
            wren_q     <= 1'b0;
            waddr_q    <= ADDR_ZERO;
            din_q      <= DATA_ZERO;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
            tick_q     <= TICK_ZERO;
            raddr_q    <= ADDR_ZERO;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            wren_q     <= wren_d;
            waddr_q    <= waddr_d;
            din_q      <= din_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tick_q     <= tick_d;
            raddr_q    <= raddr_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin history; resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign ack_o       = ack_q;
    assign clr_busy_o  = busy_q;
    assign ram_wren_o  = wren_q;
    assign ram_waddr_o = waddr_q;
    assign ram_din_o   = din_q;
    assign ram_raddr_o = raddr_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_access_arbiter
//
// Directed bench for ram_access_arbiter. Stimulus tasks push the expected
// write-port activity (with the cycle it must appear in) and the expected
// read-address steps into queues; two monitors pop and compare whenever the
// DUT writes or its read address moves.
// -----------------------------------------------------------------------------
module tb_ram_access_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic [1:0]    req      = 2'b00;
    logic [AW-1:0] addr0    = 5'd0;
    logic [DW-1:0] data0    = 8'h00;
    logic [AW-1:0] addr1    = 5'd0;
    logic [DW-1:0] data1    = 8'h00;
    logic          clr_start = 1'b0;
    logic          scan_en  = 1'b0;
    logic [1:0]    ack;
    logic          clr_busy;
    logic          ram_wren;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_raddr;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    k;
        logic          b;
    } wr_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] v;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    logic [AW-1:0] prev_raddr = 5'd0;

    ram_access_arbiter #(
        .AW(AW), .DW(DW), .TICKS(4), .TW(3)
    ) dut (
        .clock_i    (clk),
        .resetn_i   (rst_n),
        .req_i      (req),
        .addr0_i    (addr0),
        .data0_i    (data0),
        .addr1_i    (addr1),
        .data1_i    (data1),
        .ack_o      (ack),
        .clr_start_i(clr_start),
        .clr_busy_o (clr_busy),
        .scan_en_i  (scan_en),
        .ram_wren_o (ram_wren),
        .ram_waddr_o(ram_waddr),
        .ram_din_o  (ram_din),
        .ram_raddr_o(ram_raddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every write cycle must match the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (ram_wren) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: cyc=%0d addr=%0d din=%h ack=%b busy=%b, required no write",
                         cyc, ram_waddr, ram_din, ack, clr_busy);
            end else begin
                e = wq.pop_front();
                if (e.cyc != cyc || e.a !== ram_waddr || e.d !== ram_din ||
                    e.k !== ack || e.b !== clr_busy) begin
                    n_fail++;
                    $display("FAIL write: got cyc=%0d addr=%0d din=%h ack=%b busy=%b, required cyc=%0d addr=%0d din=%h ack=%b busy=%b",
                             cyc, ram_waddr, ram_din, ack, clr_busy, e.cyc, e.a, e.d, e.k, e.b);
                end
            end
        end else if (ack != 2'b00) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: cyc=%0d ack=%b without write, required 00", cyc, ack);
        end
    end

    // Read-scan monitor: every change of the read address must be expected.
    always @(negedge clk) begin
        rd_t e;
        if (ram_raddr !== prev_raddr) begin
            n_checks++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_raddr: cyc=%0d raddr=%0d, required %0d", cyc, ram_raddr, prev_raddr);
            end else begin
                e = rq.pop_front();
                if (e.cyc != cyc || e.v !== ram_raddr) begin
                    n_fail++;
                    $display("FAIL raddr_step: got cyc=%0d raddr=%0d, required cyc=%0d raddr=%0d",
                             cyc, ram_raddr, e.cyc, e.v);
                end
            end
            prev_raddr <= ram_raddr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic void exp_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [1:0] k, input logic b);
        wr_t e;
        e.cyc = c; e.a = a; e.d = d; e.k = k; e.b = b;
        wq.push_back(e);
    endfunction

    function automatic void exp_clear(input int c0, input int n);
        for (int i = 0; i < n; i++) exp_wr(c0 + i, AW'(i), 8'h00, 2'b00, 1'b1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    // Both requesters raise req together; each drops its bit after its own ack.
    task automatic run_pair(input logic first);
        int c;
        c = cyc;
        req = 2'b11; addr0 = 5'd3; data0 = 8'h11; addr1 = 5'd7; data1 = 8'h22;
        if (first) begin
            exp_wr(c + 1, 5'd7, 8'h22, 2'b10, 1'b0);
            exp_wr(c + 3, 5'd3, 8'h11, 2'b01, 1'b0);
        end else begin
            exp_wr(c + 1, 5'd3, 8'h11, 2'b01, 1'b0);
            exp_wr(c + 3, 5'd7, 8'h22, 2'b10, 1'b0);
        end
        tick();
        req = first ? 2'b01 : 2'b10;
        ticks(2);
        req = 2'b00;
        tick();
    endtask

    initial begin
        int c;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wren",  {31'd0, ram_wren}, 32'd0);
        check("rst_waddr", {27'd0, ram_waddr}, 32'd0);
        check("rst_din",   {24'd0, ram_din}, 32'd0);
        check("rst_raddr", {27'd0, ram_raddr}, 32'd0);
        check("rst_ack",   {30'd0, ack}, 32'd0);
        check("rst_busy",  {31'd0, clr_busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 0.
        c = cyc;
        req = 2'b01; addr0 = 5'd5; data0 = 8'hA5;
        exp_wr(c + 1, 5'd5, 8'hA5, 2'b01, 1'b0);
        tick();
        req = 2'b00;
        tick();
        check("t1_wren_after", {31'd0, ram_wren}, 32'd0);
        check("t1_ack_after",  {30'd0, ack}, 32'd0);

        // Tie right after requester 0 was served.
`ifdef ARB_FIXED_PRIO_EN
        run_pair(1'b0);
`else
        run_pair(1'b1);
`endif

        // Tie straight out of reset: requester 0 first in both modes.
        do_reset();
        run_pair(1'b0);

        // Bulk clear with a request from requester 1 raised mid-clear.
        c = cyc;
        clr_start = 1'b1;
        exp_clear(c + 1, 32);
        exp_wr(c + 34, 5'd9, 8'h77, 2'b10, 1'b0);
        tick();
        clr_start = 1'b0;
        ticks(10);
        req = 2'b10; addr1 = 5'd9; data1 = 8'h77;
        ticks(21);
        check("t3_busy_last", {31'd0, clr_busy}, 32'd1);
        tick();
        check("t3_busy_exit", {31'd0, clr_busy}, 32'd0);
        check("t3_wren_exit", {31'd0, ram_wren}, 32'd0);
        tick();
        req = 2'b00;
        tick();

        // clr_start and req in the same idle cycle: clear first.
        c = cyc;
        clr_start = 1'b1; req = 2'b01; addr0 = 5'd4; data0 = 8'h3C;
        exp_clear(c + 1, 32);
        exp_wr(c + 34, 5'd4, 8'h3C, 2'b01, 1'b0);
        tick();
        clr_start = 1'b0;
        ticks(33);
        req = 2'b00;
        tick();

        // clr_start during a write is deferred to the next idle cycle.
        c = cyc;
        req = 2'b01; addr0 = 5'd17; data0 = 8'h5E;
        exp_wr(c + 1, 5'd17, 8'h5E, 2'b01, 1'b0);
        exp_clear(c + 3, 32);
        tick();
        req = 2'b00; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        ticks(35);

        // Reset asserted while the clear shows address 12.
        c = cyc;
        clr_start = 1'b1;
        exp_clear(c + 1, 13);
        tick();
        clr_start = 1'b0;
        ticks(12);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wren",  {31'd0, ram_wren}, 32'd0);
        check("t6_rst_waddr", {27'd0, ram_waddr}, 32'd0);
        check("t6_rst_busy",  {31'd0, clr_busy}, 32'd0);
        check("t6_rst_ack",   {30'd0, ack}, 32'd0);
        ticks(2);
        rst_n = 1'b1;
        tick();
        check("t6_busy_after", {31'd0, clr_busy}, 32'd0);
        c = cyc;
        req = 2'b10; addr1 = 5'd2; data1 = 8'h5A;
        exp_wr(c + 1, 5'd2, 8'h5A, 2'b10, 1'b0);
        tick();
        req = 2'b00;
        ticks(2);

        // Read scan with a 4-cycle tick: 33 steps wrap 31 -> 0 -> 1, then hold.
        c = cyc;
        scan_en = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            rd_t e;
            e.cyc = c + 4 * k;
            e.v   = AW'(k % 32);
            rq.push_back(e);
        end
        ticks(132);
        scan_en = 1'b0;
        ticks(10);
        check("scan_hold", {27'd0, ram_raddr}, 32'd1);

        ticks(2);
        check("wr_queue_drained", wq.size(), 32'd0);
        check("rd_queue_drained", rq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Controller in front of the 32x8 dual-port RAM (`ram2portlpm`).
- Shares the single write port between two requesters (req/ack handshake) and runs a bulk-clear sequencer that zero-fills all 32 words.
- Also drives the read port with a free-running scan address that advances once per tick period.
- Sits between the board I/O logic (switches/keys) and the RAM instance at top level.

Parameters:
- AW, 5, address width; depth is 2**AW words.
- DW, 8, data width.
- TICKS, 50000000, number of Clock cycles per read-address step.
- TW, 26, width of the tick divider counter; must satisfy 2**TW >= TICKS.

Ports:
- Clock  input  1  system clock (CLOCK_50 at top level).
- Resetn  input  1  asynchronous active-low reset.
- req  input  2  write request per requester; bit i belongs to requester i.
- addr0  input  AW  requester 0 write address.
- data0  input  DW  requester 0 write data.
- addr1  input  AW  requester 1 write address.
- data1  input  DW  requester 1 write data.
- ack  output  2  one-cycle grant/done pulse per requester.
- clr_start  input  1  pulse that starts the bulk clear.
- clr_busy  output  1  high while the clear runs.
- scan_en  input  1  enables read-address stepping.
- ram_wren  output  1  RAM write enable.
- ram_waddr  output  AW  RAM write address.
- ram_din  output  DW  RAM write data.
- ram_raddr  output  AW  RAM read address.

Behaviour:
- Clock domain: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: ram_wren=0, ram_waddr=0, ram_din=0, ram_raddr=0, ack=00, clr_busy=0. Internal state: FSM=IDLE, clear pending=0, last_grant=1, tick counter=0.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE, priority order:
  - clear pending or clr_start → CLEAR. Load clear address=0, set clr_busy=1, clear the pending flag.
  - else any req → WRITE with the winner's address and data latched into ram_waddr/ram_din, ram_wren=1, and ack[winner]=1 (all in the same registered cycle).
- Arbitration: round-robin. When both requests are high, the requester not equal to last_grant wins; a single request wins outright. last_grant updates on each grant.
- WRITE: lasts exactly 1 cycle; ram_wren and ack deassert on the next edge and the FSM returns to IDLE.
- Handshake:
  - Requester holds req, addr and data stable until it samples ack=1.
  - It must drop req on that same edge.
  - A req still high in IDLE is a new request.
  - Latency from req seen to write/ack is 1 cycle; maximum throughput is 1 write per 2 cycles.
- CLEAR:
  - Writes ram_din=0 to addresses 0..2**AW-1, one per cycle, with ram_wren=1.
  - After the last address (31) it returns to IDLE with clr_busy=0 and ram_wren=0: 32 write cycles, plus 1 cycle to exit.
  - req is ignored and no ack is issued during CLEAR; requests stay pending and are serviced afterwards.
- clr_start while in WRITE or CLEAR: latched as pending and serviced on the next IDLE; a clear never restarts mid-run.
- Simultaneous clr_start and req in IDLE: clear wins, and the request waits.
- Read scan:
  - While scan_en=1, the tick counter counts 0..TICKS-1 and wraps.
  - On the wrap cycle, ram_raddr increments modulo 2**AW (31→0).
  - scan_en=0 holds both the counter and ram_raddr.
  - The scan is independent of the FSM.
- Reset mid-operation (any state): everything immediately returns to its reset values and any partial clear is abandoned.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined: requester 0 always wins when both requests are high, and last_grant is unused.
- When undefined: round-robin as specified above.

Test Plan:
- Reset, then req=01, addr0=5, data0=8'hA5 → next cycle ram_wren=1, ram_waddr=5, ram_din=A5, ack=01. The cycle after: ram_wren=0, ack=00.
- req=11 held, each requester dropping its req after its own ack → grants alternate 0 then 1 (last_grant resets to 1), one grant per 2 cycles. With ARB_FIXED_PRIO_EN defined, requester 0 is granted first.
- clr_start pulse in IDLE → clr_busy=1 for 32 cycles, ram_waddr steps 0..31 with ram_din=0 and ram_wren=1. req=10 raised mid-clear gets no ack until clr_busy falls, then is granted.
- clr_start and req=01 in the same IDLE cycle → CLEAR runs first; ack[0] arrives 1 cycle after the clear exits.
- TICKS=4, scan_en=1 → ram_raddr increments every 4 cycles and wraps 31→0. With scan_en=0 for 10 cycles, ram_raddr holds its value.
- Resetn asserted low at clear address 12 → outputs go to reset values asynchronously. After release, FSM is IDLE and clr_busy=0.
